fully_connected_network: RTL and testbench
==========================================

FULLY_CONNECTED_NETWORK -- requirements
Module: fully_connected_network

Interface
REQ-001 SHALL have parameter NUM_LAYER1, default 10: number of layer-1 neurons.
REQ-002 SHALL have parameter NUM_LAYER2, default 5: number of layer-2 neurons.
REQ-003 SHALL have parameter THRESHOLD, default 8'd1: fallback threshold, used whenever the threshold port is 0.
REQ-004 SHALL have parameter REFRACTORY_PERIOD, default 5: documented default for the refractory_period port; the datapath does not read it.
REQ-005 SHALL have parameter SYNAPSE_WEIGHTS, default 50'b0: documented default weight image; the datapath uses only the synapse_weights port.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 current_input  input  16  input spike/current vector, sampled every cycle.
REQ-010 threshold  input  8  firing threshold, unsigned.
REQ-011 refractory_period  input  8  refractory length in cycles, unsigned.
REQ-012 synapse_weights  input  NUM_LAYER1*NUM_LAYER2  binary weights; bit j*NUM_LAYER1+i connects layer-1 neuron i to layer-2 neuron j.
REQ-013 spike_output  output  NUM_LAYER1  registered layer-1 spikes.
REQ-014 spike_output_layer2  output  NUM_LAYER2  registered layer-2 spikes.

Function
REQ-015 Layer-1 neuron i SHALL receive a 2-bit current I1[i] = {current_input[i+6], current_input[i]}, range 0..3.
REQ-016 Layer-2 neuron j SHALL receive I2[j] = count of i where spike_output[i] & synapse_weights[j*NUM_LAYER1+i], range 0..NUM_LAYER1.
REQ-017 Each neuron SHALL hold an 8-bit unsigned membrane V and an 8-bit refractory counter R.
REQ-018 Effective threshold TH SHALL be the threshold port value, or THRESHOLD when the port is 0.
REQ-019 When R != 0 the neuron SHALL ignore its input, hold V at 0, decrement R and emit no spike.
REQ-020 When R == 0 the neuron SHALL form S = V + I, saturating at 255.
REQ-021 If S >= TH the neuron SHALL spike, with V <= 0 and R <= refractory_period.
REQ-022 If S < TH the neuron SHALL set V <= S.
REQ-023 Spike outputs SHALL be registered one-cycle pulses.
REQ-024 Layer-1 latency: current_input sampled at edge N gives spike_output after edge N.
REQ-025 Layer-2 latency: layer-2 neurons consume the registered spike_output, so a layer-1 spike after edge N gives spike_output_layer2 after edge N+1.
REQ-026 refractory_period = 0 SHALL allow a neuron to fire on consecutive cycles.
REQ-027 threshold = 255 with V = 255 saturated SHALL fire.
REQ-028 Port changes SHALL take effect on the next edge, with no latching.

Reset
REQ-029 While reset = 1 at an edge, every V, R, spike_output and spike_output_layer2 SHALL become 0.
REQ-030 Reset mid-operation SHALL discard in-progress membranes and refractory state.
REQ-031 The first spike after reset release SHALL depend only on post-reset inputs.

Configuration
REQ-032 With macro FCN_LEAK_EN defined, a non-refractory, non-firing neuron with I = 0 and V > 0 SHALL decrement V by 1 per cycle.
REQ-033 Without FCN_LEAK_EN, V SHALL hold when I = 0 (pure integrate-and-fire).

Verification
REQ-034 threshold=1, refractory=5, current_input=16'hAAAA held, weights 50'h2AAAAAAAAAAAA -> spike_output=10'b1010101010 one cycle after release, repeating every 6 cycles; spike_output_layer2=5'b11111 one cycle after each layer-1 spike.
REQ-035 threshold=0 port, THRESHOLD=1, current_input=16'h0001 -> neuron 0 fires (I=1), all other layer-1 outputs 0.
REQ-036 threshold=10, refractory=0, current_input=16'h0041 (I1[0]=3) -> neuron 0 fires on 4th sampled cycle (3,6,9,12>=10), then V restarts at 0 (without FCN_LEAK_EN).
REQ-037 synapse_weights=0, any input -> spike_output_layer2 stays 0.
REQ-038 Reset asserted for 1 cycle mid-refractory -> all outputs 0 next cycle; the neuron fires on the first post-reset cycle with S >= TH.
REQ-039 FCN_LEAK_EN defined, threshold=8, one cycle of I=3, then input 0 -> V goes 3,2,1,0 and no spike.

Source files
------------

// File: rtl/fully_connected_network.sv
// fully_connected_network
// Two-layer binary-weight spiking network built from integrate-and-fire neurons.
// Layer 1 has NUM_LAYER1 neurons. Each one takes a 2-bit current taken from
// current_input. Layer 2 has NUM_LAYER2 neurons. Each one counts the registered
// layer-1 spikes that reach it through synapse_weights.
//
// Optional feature: define FCN_LEAK_EN to add a leak. A neuron that is idle
// (not refractory, not firing, zero input) then loses one unit of membrane
// per cycle. With the macro undefined, an idle neuron holds its membrane.
module fully_connected_network #(
  parameter int                                NUM_LAYER1        = 10,
  parameter int                                NUM_LAYER2        = 5,
  parameter logic [7:0]                        THRESHOLD         = 8'd1,
  parameter int                                REFRACTORY_PERIOD = 5,
  parameter logic [NUM_LAYER1*NUM_LAYER2-1:0]  SYNAPSE_WEIGHTS   = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [15:0]                          current_input,
  input  logic [7:0]                           threshold,
  input  logic [7:0]                           refractory_period,
  input  logic [NUM_LAYER1*NUM_LAYER2-1:0]     synapse_weights,
  output logic [NUM_LAYER1-1:0]                spike_output,
  output logic [NUM_LAYER2-1:0]                spike_output_layer2
);

  // The current_input mapping {bit i+6, bit i} only covers ten layer-1 neurons.
  // REFRACTORY_PERIOD and SYNAPSE_WEIGHTS are documented defaults only.
  // The datapath does not read them, so they are only range-checked here.
  if (NUM_LAYER1 > 10) begin : g_bad_layer1
    $error("NUM_LAYER1 above 10 has no current_input mapping");
  end
  if (REFRACTORY_PERIOD > 255 || $bits(SYNAPSE_WEIGHTS) != NUM_LAYER1 * NUM_LAYER2) begin : g_bad_defaults
    $error("REFRACTORY_PERIOD or SYNAPSE_WEIGHTS default is out of range");
  end

  typedef struct packed {
    logic       fire;
    logic [7:0] v;
    logic [7:0] r;
  } step_t;

  logic [7:0] v1 [NUM_LAYER1];
  logic [7:0] r1 [NUM_LAYER1];
  logic [7:0] v2 [NUM_LAYER2];
  logic [7:0] r2 [NUM_LAYER2];

  step_t      step1 [NUM_LAYER1];
  step_t      step2 [NUM_LAYER2];
  logic [7:0] eff_th;

  // One neuron update. A refractory neuron clamps V to 0 and counts R down.
  // Otherwise the neuron integrates with saturation and fires at or above
  // the threshold.
  function automatic step_t neuron_step(input logic [7:0]  v,
                                        input logic [7:0]  r,
                                        input logic [15:0] cur,
                                        input logic [7:0]  th,
                                        input logic [7:0]  rp);
    step_t      res;
    logic [16:0] sum;
    logic [7:0]  s;
    res = '0;
    sum = {9'd0, v} + {1'b0, cur};
    s   = (sum > 17'd255) ? 8'hFF : sum[7:0];
    if (r != 8'd0) begin
      res.fire = 1'b0;
      res.v    = 8'd0;
      res.r    = r - 8'd1;
    end else if (s >= th) begin
      res.fire = 1'b1;
      res.v    = 8'd0;
      res.r    = rp;
    end else begin
      res.fire = 1'b0;
      res.v    = s;
      res.r    = 8'd0;
`ifdef FCN_LEAK_EN
      if (cur == 16'd0 && v != 8'd0) begin
        res.v = v - 8'd1;
      end
`endif
    end
    return res;
  endfunction

  // A zero on the threshold port selects the THRESHOLD parameter as fallback
  always_comb begin
    eff_th = (threshold == 8'd0) ? THRESHOLD : threshold;
  end

  // Layer-1 next state from the 2-bit current of each neuron
  always_comb begin
    for (int i = 0; i < NUM_LAYER1; i++) begin
      step1[i] = neuron_step(v1[i], r1[i],
                             {14'd0, current_input[i+6], current_input[i]},
                             eff_th, refractory_period);
    end
  end

  // Layer-2 next state. Each neuron counts the weighted registered layer-1
  // spikes, which adds the extra cycle of latency through the second layer.
  always_comb begin
    for (int j = 0; j < NUM_LAYER2; j++) begin
      logic [15:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_LAYER1; i++) begin
        cnt = cnt + 16'(spike_output[i] & synapse_weights[j*NUM_LAYER1+i]);
      end
      step2[j] = neuron_step(v2[j], r2[j], cnt, eff_th, refractory_period);
    end
  end

  // Register membranes, refractory counters and spike pulses.
  // Reset clears every neuron's state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYER1; i++) begin
        v1[i] <= 8'd0;
        r1[i] <= 8'd0;
      end
      for (int j = 0; j < NUM_LAYER2; j++) begin
        v2[j] <= 8'd0;
        r2[j] <= 8'd0;
      end
      spike_output        <= '0;
      spike_output_layer2 <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYER1; i++) begin
        v1[i]           <= step1[i].v;
        r1[i]           <= step1[i].r;
        spike_output[i] <= step1[i].fire;
      end
      for (int j = 0; j < NUM_LAYER2; j++) begin
        v2[j]                  <= step2[j].v;
        r2[j]                  <= step2[j].r;
        spike_output_layer2[j] <= step2[j].fire;
      end
    end
  end

endmodule

// File: tb/tb_fully_connected_network.sv
// tb_fully_connected_network
// Directed bench for fully_connected_network. Every step drives one cycle of
// inputs, pushes the spike pattern expected after that edge onto a scoreboard,
// then pops it and compares it with the registered outputs.
// Expectations for FCN_LEAK_EN builds are selected with the same macro.
module tb_fully_connected_network;

  localparam int NL1 = 10;
  localparam int NL2 = 5;
  localparam int NW  = NL1 * NL2;

  localparam logic [NW-1:0] W_ODD  = 50'h2AAAAAAAAAAAA;
  localparam logic [NW-1:0] W_NONE = 50'h0;
  localparam logic [NW-1:0] W_N1   = 50'h200002;

  logic            clk = 1'b0;
  logic            reset;
  logic [15:0]     current_input;
  logic [7:0]      threshold;
  logic [7:0]      refractory_period;
  logic [NW-1:0]   synapse_weights;
  logic [NL1-1:0]  spike_output;
  logic [NL2-1:0]  spike_output_layer2;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [NL1-1:0] l1;
    logic [NL2-1:0] l2;
    string          tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fully_connected_network #(
    .NUM_LAYER1(NL1),
    .NUM_LAYER2(NL2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .current_input      (current_input),
    .threshold          (threshold),
    .refractory_period  (refractory_period),
    .synapse_weights    (synapse_weights),
    .spike_output       (spike_output),
    .spike_output_layer2(spike_output_layer2)
  );

  // Compare the outputs after an edge with the oldest scoreboard entry
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%b/%b expected=entry", spike_output, spike_output_layer2);
      return;
    end
    e = sb_q.pop_front();
    vectors++;
    assert (spike_output === e.l1) else begin
      miscompares++;
      $error("[TB] FAIL %s spike_output observed=%b expected=%b", e.tag, spike_output, e.l1);
    end
    assert (spike_output_layer2 === e.l2) else begin
      miscompares++;
      $error("[TB] FAIL %s spike_output_layer2 observed=%b expected=%b", e.tag, spike_output_layer2, e.l2);
    end
  endtask

  // Drive one cycle of inputs away from the edge, record the expected result, then check it
  task automatic applyStimulus(input logic [15:0]    ci,
                               input logic [7:0]     th,
                               input logic [7:0]     rp,
                               input logic [NW-1:0]  w,
                               input logic           rst,
                               input logic [NL1-1:0] e1,
                               input logic [NL2-1:0] e2,
                               input string          tag);
    exp_t e;
    @(negedge clk);
    current_input     = ci;
    threshold         = th;
    refractory_period = rp;
    synapse_weights   = w;
    reset             = rst;
    e.l1  = e1;
    e.l2  = e2;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset             = 1'b1;
    current_input     = 16'h0;
    threshold         = 8'd1;
    refractory_period = 8'd5;
    synapse_weights   = W_NONE;

    // Reset state
    applyStimulus(16'hAAAA, 8'd1, 8'd5, W_ODD, 1'b1, 10'h000, 5'h00, "reset0");
    applyStimulus(16'hAAAA, 8'd1, 8'd5, W_ODD, 1'b1, 10'h000, 5'h00, "reset1");

    // Odd neurons get I=3 and fire every 6 cycles. Layer 2 follows one cycle later.
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(16'hAAAA, 8'd1, 8'd5, W_ODD, 1'b0,
                    (k % 6 == 1) ? 10'b1010101010 : 10'h000,
                    (k % 6 == 2) ? 5'b11111 : 5'h00, "pattern_aaaa");
    end

    // Reset while layer 1 is refractory. It fires again right after release.
    applyStimulus(16'hAAAA, 8'd1, 8'd5, W_ODD, 1'b1, 10'h000, 5'h00, "mid_reset");
    applyStimulus(16'hAAAA, 8'd1, 8'd5, W_ODD, 1'b0, 10'b1010101010, 5'h00, "post_reset_l1");
    applyStimulus(16'hAAAA, 8'd1, 8'd5, W_ODD, 1'b0, 10'h000, 5'b11111, "post_reset_l2");

    // Zero weights silence layer 2. A zero refractory period fires every cycle.
    applyStimulus(16'hAAAA, 8'd1, 8'd0, W_NONE, 1'b1, 10'h000, 5'h00, "reset_w0");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(16'hAAAA, 8'd1, 8'd0, W_NONE, 1'b0, 10'b1010101010, 5'h00, "w0_consecutive");
    end

    // A zero threshold port falls back to THRESHOLD=1. Only neuron 0 sees current.
    applyStimulus(16'h0001, 8'd0, 8'd5, W_NONE, 1'b1, 10'h000, 5'h00, "reset_th0");
    applyStimulus(16'h0001, 8'd0, 8'd5, W_NONE, 1'b0, 10'h001, 5'h00, "th0_fire");
    applyStimulus(16'h0001, 8'd0, 8'd5, W_NONE, 1'b0, 10'h000, 5'h00, "th0_refractory");

    // threshold=10: neuron 0 (I=3) fires every 4th cycle. Neuron 6 (I=1) fires on the 10th.
    applyStimulus(16'h0041, 8'd10, 8'd0, W_NONE, 1'b1, 10'h000, 5'h00, "reset_th10");
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(16'h0041, 8'd10, 8'd0, W_NONE, 1'b0,
                    (k == 10) ? 10'h040 : ((k % 4 == 0) ? 10'h001 : 10'h000),
                    5'h00, "th10_integrate");
    end

    // Neuron 1 spikes every 2nd cycle. Layer-2 neurons 0 and 2 need two of those spikes.
    applyStimulus(16'h0002, 8'd2, 8'd0, W_N1, 1'b1, 10'h000, 5'h00, "reset_l2count");
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(16'h0002, 8'd2, 8'd0, W_N1, 1'b0,
                    (k % 2 == 0) ? 10'h002 : 10'h000,
                    (k == 5 || k == 9) ? 5'b00101 : 5'h00, "l2_count");
    end

    // Reach V=254 with I=2. Then I=3 saturates to 255 and fires at threshold 255.
    applyStimulus(16'h0040, 8'd255, 8'd0, W_NONE, 1'b1, 10'h000, 5'h00, "reset_sat");
    for (int k = 1; k <= 127; k++) begin
      applyStimulus(16'h0040, 8'd255, 8'd0, W_NONE, 1'b0, 10'h000, 5'h00, "sat_climb");
    end
    applyStimulus(16'h0041, 8'd255, 8'd0, W_NONE, 1'b0, 10'h001, 5'h00, "sat_fire");

    // One pulse of I=3, three idle cycles, then I=3 until neuron 0 reaches threshold 9
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b1, 10'h000, 5'h00, "reset_leak");
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b0, 10'h000, 5'h00, "leak_load");
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(16'h0000, 8'd9, 8'd0, W_NONE, 1'b0, 10'h000, 5'h00, "leak_idle");
    end
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b0, 10'h000, 5'h00, "leak_reload");
`ifdef FCN_LEAK_EN
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b0, 10'h000, 5'h00, "leak_no_fire");
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b0, 10'h001, 5'h00, "leak_fire");
`else
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b0, 10'h001, 5'h00, "hold_fire");
    applyStimulus(16'h0041, 8'd9, 8'd0, W_NONE, 1'b0, 10'h000, 5'h00, "hold_restart");
`endif

    if (sb_q.size() != 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
